// File: rtl/game_pkg.sv
// Shared constants for the colour-wheel game: palette, screen geometry, LFSR seed.
package game_pkg;

  localparam logic [2:0] COL_BLUE   = 3'b001;
  localparam logic [2:0] COL_GREEN  = 3'b010;
  localparam logic [2:0] COL_YELLOW = 3'b110;
  localparam logic [2:0] COL_RED    = 3'b100;
  localparam logic [2:0] BG_COLOUR  = 3'b000;

  localparam logic [7:0] BALL_X    = 8'd78;
  localparam logic [6:0] Y_START   = 7'd0;
  localparam logic [6:0] Y_LAND    = 7'd119;
  localparam logic [7:0] LFSR_SEED = 8'hA5;

  function automatic logic [2:0] col_from_bits(input logic [1:0] sel);
    case (sel)
      2'b00:   return COL_BLUE;
      2'b01:   return COL_GREEN;
      2'b10:   return COL_YELLOW;
      default: return COL_RED;
    endcase
  endfunction

endpackage

// File: rtl/rate_divider.sv
// Down-counter frame tick generator: 1-cycle tick when the count hits 0 while enabled.
// Reload restarts the period without emitting a tick; disabled holds the count.
module rate_divider #(
  parameter int             W      = 20,
  parameter logic [W-1:0]   RELOAD = '1
) (
  input  logic clock,
  input  logic resetn,
  input  logic en_i,
  input  logic reload_i,
  output logic tick_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tick_o = en_i && !reload_i && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (reload_i)        cnt_d = RELOAD;
    else if (tick_o)     cnt_d = RELOAD;
    else if (en_i)       cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) cnt_q <= RELOAD;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ball_datapath.sv
// Game datapath: frame tick, frame count, 4x4 sprite walk, falling ball y and colour LFSR.
// VGA x/y/colour are combinational from registered state; plot is write_en delayed one clock.
module ball_datapath
  import game_pkg::*;
#(
  parameter int CLK_PER_FRAME = 833334
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       rate_en,
  input  logic       frames_en,
  input  logic       reset_en,
  input  logic       auto_reset,
  input  logic       enable_y,
  input  logic       enable_cnt,
  input  logic       select_col,
  input  logic       write_en,
  input  logic       new_col_en,
  input  logic [6:0] speed,
  output logic [3:0] counter,
  output logic [4:0] frames,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour,
  output logic       plot,
  output logic [6:0] ball_y,
  output logic [2:0] ball_col,
  output logic       landed
);

  localparam int         DIV_W      = (CLK_PER_FRAME > 1) ? $clog2(CLK_PER_FRAME) : 1;
  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLK_PER_FRAME - 1);

  logic       tick;
  logic [3:0] counter_q, counter_d;
  logic [4:0] frames_q,  frames_d;
  logic [6:0] ball_y_q,  ball_y_d;
  logic [2:0] ball_col_q, ball_col_d;
  logic [7:0] lfsr_q,    lfsr_d;
  logic       plot_q;
  logic [2:0] step;
  logic [7:0] y_sum;
  logic       unused_speed;

  rate_divider #(
    .W      (DIV_W),
    .RELOAD (DIV_RELOAD)
  ) u_rate_divider (
    .clock    (clock),
    .resetn   (resetn),
    .en_i     (rate_en),
    .reload_i (auto_reset),
    .tick_o   (tick)
  );

  // Only the low three speed bits set the step; zero still moves one row.
  assign unused_speed = ^speed[6:3];
  assign step  = (speed[2:0] == 3'd0) ? 3'd1 : speed[2:0];
  assign y_sum = {1'b0, ball_y_q} + {5'd0, step};

  always_comb begin
    frames_d = frames_q;
    if (auto_reset)            frames_d = 5'd0;
    else if (reset_en)         frames_d = 5'd0;
    else if (tick && frames_en) frames_d = frames_q + 5'd1;
  end

  always_comb begin
    counter_d = counter_q;
    if (auto_reset)      counter_d = 4'd0;
    else if (enable_cnt) counter_d = counter_q + 4'd1;
  end

  always_comb begin
    ball_y_d = ball_y_q;
    if (auto_reset)             ball_y_d = Y_START;
    else if (tick && enable_y)  ball_y_d = (y_sum >= {1'b0, Y_LAND}) ? Y_LAND : y_sum[6:0];
  end

  always_comb begin
    lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    ball_col_d = new_col_en ? col_from_bits(lfsr_q[1:0]) : ball_col_q;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      counter_q  <= 4'd0;
      frames_q   <= 5'd0;
      ball_y_q   <= Y_START;
      ball_col_q <= COL_BLUE;
      lfsr_q     <= LFSR_SEED;
      plot_q     <= 1'b0;
    end else begin
      counter_q  <= counter_d;
      frames_q   <= frames_d;
      ball_y_q   <= ball_y_d;
      ball_col_q <= ball_col_d;
      lfsr_q     <= lfsr_d;
      plot_q     <= write_en;
    end
  end

  assign counter  = counter_q;
  assign frames   = frames_q;
  assign ball_y   = ball_y_q;
  assign ball_col = ball_col_q;
  assign plot     = plot_q;
  assign landed   = (ball_y_q >= Y_LAND);
  assign x_out    = BALL_X + {6'd0, counter_q[1:0]};
  assign y_out    = ball_y_q + {5'd0, counter_q[3:2]};
  assign colour   = select_col ? BG_COLOUR : ball_col_q;

endmodule

// File: tb/tb_ball_datapath.sv
// Scoreboard bench for ball_datapath with a short frame period.
module tb_ball_datapath;

  localparam int CPF = 4;

  logic       clock = 1'b0;
  logic       resetn;
  logic       rate_en, frames_en, reset_en, auto_reset, enable_y, enable_cnt;
  logic       select_col, write_en, new_col_en;
  logic [6:0] speed;
  logic [3:0] counter;
  logic [4:0] frames;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour;
  logic       plot;
  logic [6:0] ball_y;
  logic [2:0] ball_col;
  logic       landed;

  ball_datapath #(.CLK_PER_FRAME(CPF)) dut (
    .clock(clock), .resetn(resetn), .rate_en(rate_en), .frames_en(frames_en),
    .reset_en(reset_en), .auto_reset(auto_reset), .enable_y(enable_y),
    .enable_cnt(enable_cnt), .select_col(select_col), .write_en(write_en),
    .new_col_en(new_col_en), .speed(speed), .counter(counter), .frames(frames),
    .x_out(x_out), .y_out(y_out), .colour(colour), .plot(plot), .ball_y(ball_y),
    .ball_col(ball_col), .landed(landed)
  );

  always #5 clock = ~clock;

  typedef struct {
    int cnt; int frm; int y; int col; int plt; int lnd; int x; int yo; int clr;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int         m_div, m_frames, m_cnt, m_y, m_col, m_plot;
  logic [7:0] m_lfsr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int col_map(input logic [1:0] b);
    case (b)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 6;
      default: return 4;
    endcase
  endfunction

  task automatic model_reset();
    m_div = CPF - 1; m_frames = 0; m_cnt = 0; m_y = 0; m_col = 1; m_plot = 0;
    m_lfsr = 8'hA5;
  endtask

  // Advance the model over one clock with the inputs currently driven, push the
  // prediction, then compare after the edge.
  task automatic cycle();
    exp_t e;
    logic tick;
    int   st;
    tick = rate_en && (m_div == 0) && !auto_reset;
    st   = (speed[2:0] == 0) ? 1 : int'(speed[2:0]);
    if (new_col_en) m_col = col_map(m_lfsr[1:0]);
    m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    if (auto_reset)   m_div = CPF - 1;
    else if (rate_en) m_div = (m_div == 0) ? CPF - 1 : m_div - 1;
    if (auto_reset || reset_en)  m_frames = 0;
    else if (tick && frames_en)  m_frames = (m_frames + 1) % 32;
    if (auto_reset)      m_cnt = 0;
    else if (enable_cnt) m_cnt = (m_cnt + 1) % 16;
    if (auto_reset)              m_y = 0;
    else if (tick && enable_y)   m_y = (m_y + st > 119) ? 119 : m_y + st;
    m_plot = int'(write_en);
    e.cnt = m_cnt; e.frm = m_frames; e.y = m_y; e.col = m_col; e.plt = m_plot;
    e.lnd = (m_y >= 119) ? 1 : 0;
    e.x   = 78 + (m_cnt % 4);
    e.yo  = m_y + (m_cnt / 4);
    e.clr = select_col ? 0 : m_col;
    sb.push_back(e);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    chk("counter", 32'(counter), 32'(e.cnt));
    chk("frames",  32'(frames),  32'(e.frm));
    chk("ball_y",  32'(ball_y),  32'(e.y));
    chk("ball_col", 32'(ball_col), 32'(e.col));
    chk("plot",    32'(plot),    32'(e.plt));
    chk("landed",  32'(landed),  32'(e.lnd));
    chk("x_out",   32'(x_out),   32'(e.x));
    chk("y_out",   32'(y_out),   32'(e.yo));
    chk("colour",  32'(colour),  32'(e.clr));
    @(negedge clock);
  endtask

  task automatic run_until_div0();
    for (int i = 0; i < 4 * CPF && m_div != 0; i++) cycle();
  endtask

  initial begin
    bit seen31;
    logic [3:0] seen_cols;
    resetn = 1'b0;
    {rate_en, frames_en, reset_en, auto_reset, enable_y, enable_cnt} = '0;
    {select_col, write_en, new_col_en} = '0;
    speed = 7'd0;
    model_reset();
    #23;
    chk("rst_counter", 32'(counter), 0);
    chk("rst_frames",  32'(frames), 0);
    chk("rst_ball_y",  32'(ball_y), 0);
    chk("rst_ball_col", 32'(ball_col), 1);
    chk("rst_plot",    32'(plot), 0);
    @(negedge clock);
    resetn = 1'b1;

    // Frame counting and wrap.
    rate_en = 1'b1; frames_en = 1'b1;
    repeat (40) cycle();
    chk("frames_after_40", 32'(frames), 10);
    seen31 = 1'b0;
    for (int i = 0; i < 200; i++) begin
      cycle();
      if (m_frames == 31) seen31 = 1'b1;
      if (seen31 && m_frames == 0) break;
    end
    chk("frames_wrap", 32'(frames), 0);

    // Sprite walk with plot requests, divider held.
    rate_en = 1'b0; frames_en = 1'b0;
    enable_cnt = 1'b1; write_en = 1'b1;
    repeat (16) cycle();
    chk("counter_wrap", 32'(counter), 0);
    enable_cnt = 1'b0; write_en = 1'b0;
    cycle();

    // Ball fall to landing and saturation.
    auto_reset = 1'b1; cycle(); auto_reset = 1'b0;
    rate_en = 1'b1; enable_y = 1'b1; speed = 7'd5;
    for (int i = 0; i < 200 && m_y != 115; i++) cycle();
    chk("ball_y_115", 32'(ball_y), 115);
    speed = 7'h0B;
    repeat (CPF) cycle();
    chk("ball_y_118", 32'(ball_y), 118);
    chk("landed_118", 32'(landed), 0);
    repeat (CPF) cycle();
    chk("ball_y_119", 32'(ball_y), 119);
    chk("landed_119", 32'(landed), 1);
    speed = 7'd7;
    repeat (3 * CPF) cycle();
    chk("ball_y_sat", 32'(ball_y), 119);

    // auto_reset coinciding with a tick wins.
    run_until_div0();
    auto_reset = 1'b1; cycle(); auto_reset = 1'b0;
    chk("autoreset_y", 32'(ball_y), 0);
    speed = 7'd0;
    repeat (2 * CPF) cycle();
    chk("speed0_step", 32'(ball_y), 2);

    // reset_en coinciding with a tick wins.
    frames_en = 1'b1;
    repeat (3 * CPF) cycle();
    run_until_div0();
    reset_en = 1'b1; cycle(); reset_en = 1'b0;
    chk("reset_en_tick", 32'(frames), 0);

    // Erase colour, then random colour latching.
    select_col = 1'b1;
    repeat (3) cycle();
    chk("erase_colour", 32'(colour), 0);
    select_col = 1'b0;
    seen_cols = '0;
    for (int i = 0; i < 1000; i++) begin
      new_col_en = ($urandom_range(0, 2) == 0);
      cycle();
      case (ball_col)
        3'b001: seen_cols[0] = 1'b1;
        3'b010: seen_cols[1] = 1'b1;
        3'b110: seen_cols[2] = 1'b1;
        3'b100: seen_cols[3] = 1'b1;
        default: chk("col_legal", 32'(ball_col), 1);
      endcase
    end
    new_col_en = 1'b0;
    chk("all_cols_seen", 32'(seen_cols), 32'hF);

    // Asynchronous reset mid-round.
    enable_cnt = 1'b1; write_en = 1'b1;
    repeat (5) cycle();
    #2 resetn = 1'b0;
    #1;
    model_reset();
    chk("arst_counter", 32'(counter), 0);
    chk("arst_frames",  32'(frames), 0);
    chk("arst_ball_y",  32'(ball_y), 0);
    chk("arst_ball_col", 32'(ball_col), 1);
    chk("arst_plot",    32'(plot), 0);
    @(negedge clock);
    resetn = 1'b1;
    repeat (4) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
